// File: rtl/inst_split_seq_pkg.sv
// Shared constants for the fetch-to-decode micro-op splitter.
// Holds the RISC-V field values used to recognise sub-word stores and to
// build the word-load prefix beat. No ports; imported by the splitter files.
package inst_split_seq_pkg;

    localparam int          WIDTH_INST   = 32;

    localparam logic [6:0]  OPCODE_STORE = 7'b0100011;
    localparam logic [6:0]  OPCODE_LOAD  = 7'b0000011;

    localparam logic [2:0]  FUNCT3_SB    = 3'b000;
    localparam logic [2:0]  FUNCT3_SH    = 3'b001;
    localparam logic [2:0]  FUNCT3_SW    = 3'b010;
    localparam logic [2:0]  FUNCT3_LW    = 3'b010;

    localparam logic [7:0]  DEFAULT_SPLIT_MASK = 8'b0000_0011;

endpackage

// File: rtl/inst_prefix_gen.sv
// Combinational prefix generator.
// Flags stores whose funct3 is enabled in SPLIT_MASK and builds the matching
// word-load prefix: same rs1 and S-type immediate, rd = x0.
// Ports:
//   inst    in   INST_W  instruction to examine
//   match   out  1       instruction must be split
//   prefix  out  INST_W  encoding of the generated load prefix
module inst_prefix_gen
    import inst_split_seq_pkg::*;
#(
    parameter int         INST_W        = WIDTH_INST,
    parameter logic [7:0] SPLIT_MASK    = DEFAULT_SPLIT_MASK,
    parameter logic [6:0] PREFIX_OPCODE = OPCODE_LOAD,
    parameter logic [2:0] PREFIX_FUNCT3 = FUNCT3_LW
) (
    input  logic [INST_W-1:0] inst,
    output logic              match,
    output logic [INST_W-1:0] prefix
);

    assign match = (inst[6:0] == OPCODE_STORE) && SPLIT_MASK[inst[14:12]];

    // S-type immediate {imm[11:5], imm[4:0]} moves into the I-type imm slot.
    assign prefix = {inst[31:25], inst[11:7], inst[19:15], PREFIX_FUNCT3,
                     5'b00000, PREFIX_OPCODE};

endmodule

// File: rtl/inst_split_seq.sv
// Sequential micro-op splitter between fetch and decode.
// Sub-word stores leave as two beats (word-load prefix, then the store);
// everything else passes through in one beat. Output is registered, with a
// one-entry buffer holding the store while its prefix is presented.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   flush          synchronous kill of all held uops
//   in_valid/in_inst/in_ready     upstream handshake
//   out_valid/out_inst/out_is_prefix/out_is_last/out_ready  downstream handshake
//   split_cnt      instructions split since reset (wraps)
//
// state   | meaning
// S_PASS  | output holds nothing or a final beat; new instructions accepted
// S_STORE | prefix on output, store waiting in pending; upstream stalled
module inst_split_seq
    import inst_split_seq_pkg::*;
#(
    parameter int         INST_W        = WIDTH_INST,
    parameter logic [7:0] SPLIT_MASK    = DEFAULT_SPLIT_MASK,
    parameter logic [6:0] PREFIX_OPCODE = OPCODE_LOAD,
    parameter logic [2:0] PREFIX_FUNCT3 = FUNCT3_LW,
    parameter int         CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [INST_W-1:0] in_inst,
    output logic              in_ready,
    output logic              out_valid,
    output logic [INST_W-1:0] out_inst,
    output logic              out_is_prefix,
    output logic              out_is_last,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  split_cnt
);

    typedef enum logic {
        S_PASS  = 1'b0,
        S_STORE = 1'b1
    } state_t;

    state_t            state;
    logic [INST_W-1:0] pending;
    logic              match;
    logic [INST_W-1:0] prefix;
    logic              accept;

    inst_prefix_gen #(
        .INST_W        (INST_W),
        .SPLIT_MASK    (SPLIT_MASK),
        .PREFIX_OPCODE (PREFIX_OPCODE),
        .PREFIX_FUNCT3 (PREFIX_FUNCT3)
    ) u_prefix_gen (
        .inst   (in_inst),
        .match  (match),
        .prefix (prefix)
    );

    // Accept only when the output slot is free or draining this cycle.
    assign in_ready = !flush && (state == S_PASS) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_PASS;
            pending       <= '0;
            out_valid     <= 1'b0;
            out_inst      <= '0;
            out_is_prefix <= 1'b0;
            out_is_last   <= 1'b0;
            split_cnt     <= '0;
        end else if (flush) begin
            state     <= S_PASS;
            pending   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_PASS: begin
                    if (accept) begin
                        out_valid <= 1'b1;
                        if (match) begin
                            out_inst      <= prefix;
                            out_is_prefix <= 1'b1;
                            out_is_last   <= 1'b0;
                            pending       <= in_inst;
                            split_cnt     <= split_cnt + CNT_W'(1);
                            state         <= S_STORE;
                        end else begin
                            out_inst      <= in_inst;
                            out_is_prefix <= 1'b0;
                            out_is_last   <= 1'b1;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                S_STORE: begin
                    // Outputs hold until decode takes the prefix.
                    if (out_ready) begin
                        out_inst      <= pending;
                        out_is_prefix <= 1'b0;
                        out_is_last   <= 1'b1;
                        state         <= S_PASS;
                    end
                end
                default: state <= S_PASS;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_split_seq.sv
module tb_inst_split_seq;

    localparam int CNT_W = 8;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic [31:0]       in_inst;
    logic              in_ready;
    logic              out_valid;
    logic [31:0]       out_inst;
    logic              out_is_prefix;
    logic              out_is_last;
    logic              out_ready;
    logic [CNT_W-1:0]  split_cnt;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] ADD_I = 32'h00B50533;
    localparam logic [31:0] SB_I  = 32'h00A58223;
    localparam logic [31:0] SH_I  = 32'hFEA59E23;
    localparam logic [31:0] SW_I  = 32'h00A5A223;

    inst_split_seq #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_inst       (in_inst),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_inst      (out_inst),
        .out_is_prefix (out_is_prefix),
        .out_is_last   (out_is_last),
        .out_ready     (out_ready),
        .split_cnt     (split_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        bit          pre;
        bit          last;
    } uop_t;

    // Reference: a store with funct3 0 (SB) or 1 (SH) becomes LW x0, imm(rs1) + store.
    function automatic bit ref_split(input logic [31:0] i);
        return (i[6:0] == 7'h23) && (i[14:12] <= 3'd1);
    endfunction

    function automatic logic [31:0] ref_prefix(input logic [31:0] i);
        logic [11:0] imm;
        logic [4:0]  rs1;
        imm = {i[31:25], i[11:7]};
        rs1 = i[19:15];
        return (32'(imm) << 20) | (32'(rs1) << 15) | (32'd2 << 12) | 32'd3;
    endfunction

    task automatic drive(input logic v, input logic [31:0] i, input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = v;
        in_inst   = i;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; in_inst = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; in_inst = '0;
        #12;
        checks++;
        if ({out_valid, out_is_prefix, out_is_last} !== 3'b000 || out_inst !== 32'h0 || split_cnt !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b pre=%b last=%b inst=%h cnt=%0d, want all zero",
                     out_valid, out_is_prefix, out_is_last, out_inst, split_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_pass();
        drive(1'b1, ADD_I, 1'b1, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_inst !== ADD_I || out_is_last !== 1'b1 || out_is_prefix !== 1'b0 || split_cnt !== 8'd0) begin
            errors++;
            $display("FAIL add_pass: got v=%b inst=%h last=%b pre=%b cnt=%0d want v=1 inst=%h last=1 pre=0 cnt=0",
                     out_valid, out_inst, out_is_last, out_is_prefix, split_cnt, ADD_I);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_drain: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_split_sb();
        drive(1'b1, SB_I, 1'b1, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_inst !== 32'h0045A003 || out_is_prefix !== 1'b1 || out_is_last !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL sb_beat1: got v=%b inst=%h pre=%b last=%b rdy=%b want v=1 inst=0045a003 pre=1 last=0 rdy=0",
                     out_valid, out_inst, out_is_prefix, out_is_last, in_ready);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_inst !== SB_I || out_is_prefix !== 1'b0 || out_is_last !== 1'b1 || in_ready !== 1'b1 || split_cnt !== 8'd1) begin
            errors++;
            $display("FAIL sb_beat2: got v=%b inst=%h pre=%b last=%b rdy=%b cnt=%0d want v=1 inst=%h pre=0 last=1 rdy=1 cnt=1",
                     out_valid, out_inst, out_is_prefix, out_is_last, in_ready, split_cnt, SB_I);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sb_no_dup: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_stall_sh();
        drive(1'b1, SH_I, 1'b1, 1'b0);
        @(posedge clk);
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_inst !== 32'hFFC5A003 || out_is_prefix !== 1'b1 || out_is_last !== 1'b0) begin
                errors++;
                $display("FAIL sh_hold[%0d]: got v=%b inst=%h pre=%b last=%b want v=1 inst=ffc5a003 pre=1 last=0",
                         k, out_valid, out_inst, out_is_prefix, out_is_last);
            end
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_inst !== SH_I || out_is_last !== 1'b1 || out_is_prefix !== 1'b0 || split_cnt !== 8'd2) begin
            errors++;
            $display("FAIL sh_store: got v=%b inst=%h last=%b pre=%b cnt=%0d want v=1 inst=%h last=1 pre=0 cnt=2",
                     out_valid, out_inst, out_is_last, out_is_prefix, split_cnt, SH_I);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sh_no_dup: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_sw_pass();
        drive(1'b1, SW_I, 1'b1, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_inst !== SW_I || out_is_prefix !== 1'b0 || out_is_last !== 1'b1 || split_cnt !== 8'd2) begin
            errors++;
            $display("FAIL sw_pass: got v=%b inst=%h pre=%b last=%b cnt=%0d want v=1 inst=%h pre=0 last=1 cnt=2",
                     out_valid, out_inst, out_is_prefix, out_is_last, split_cnt, SW_I);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sw_single_beat: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, SB_I, 1'b1, 1'b0);
        @(posedge clk);
        drive(1'b1, ADD_I, 1'b0, 1'b1);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_ready: got %b want 0", in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_kill: out_valid got %b want 0", out_valid);
        end
        drive(1'b1, ADD_I, 1'b1, 1'b0);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_recover_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_inst !== ADD_I || out_is_last !== 1'b1 || out_is_prefix !== 1'b0) begin
            errors++;
            $display("FAIL flush_next_add: got v=%b inst=%h last=%b pre=%b want v=1 inst=%h last=1 pre=0",
                     out_valid, out_inst, out_is_last, out_is_prefix, ADD_I);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_no_store[%0d]: got v=%b inst=%h want v=0", k, out_valid, out_inst);
            end
        end
        checks++;
        if (split_cnt !== 8'd3) begin
            errors++;
            $display("FAIL flush_cnt: got %0d want 3", split_cnt);
        end
    endtask

    task automatic test_reset_mid_split();
        drive(1'b1, SH_I, 1'b0, 1'b0);
        @(posedge clk);
        drive(1'b0, '0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_is_prefix, out_is_last} !== 3'b000 || out_inst !== 32'h0 || split_cnt !== '0) begin
            errors++;
            $display("FAIL rst_mid_split: got v=%b pre=%b last=%b inst=%h cnt=%0d want all zero",
                     out_valid, out_is_prefix, out_is_last, out_inst, split_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_no_beat[%0d]: got v=%b inst=%h want v=0", k, out_valid, out_inst);
            end
        end
    endtask

    task automatic test_wrap();
        int acc;
        bit done;
        do_reset();
        acc  = 0;
        done = 0;
        drive(1'b1, SB_I, 1'b1, 1'b0);
        for (int k = 0; k < 2000 && !done; k++) begin
            if (in_ready) acc++;
            @(posedge clk); #1;
            if (acc == 255 && in_ready) begin
                checks++;
                if (split_cnt !== 8'd255) begin
                    errors++;
                    $display("FAIL wrap_max: got %0d want 255", split_cnt);
                end
            end
            if (acc == 256) done = 1;
            @(negedge clk);
            if (done) in_valid = 1'b0;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wrap_timeout: accepted %0d of 256", acc);
        end
        checks++;
        if (split_cnt !== 8'd0) begin
            errors++;
            $display("FAIL wrap_zero: got %0d want 0", split_cnt);
        end
    endtask

    task automatic test_random();
        uop_t        q[$];
        uop_t        u;
        logic [7:0]  m_cnt;
        logic [31:0] r;
        bit          exp_rdy;
        bit          acc;
        do_reset();
        m_cnt = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            r = $urandom;
            case ($urandom_range(0, 3))
                0, 1: r[6:0] = 7'h23;
                2:    r[6:0] = 7'h33;
                default: ;
            endcase
            in_inst   = r;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            #4;
            exp_rdy = !flush && (q.size() == 0 || (q.size() == 1 && out_ready));
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rnd_in_ready @%0d: got %b want %b", cyc, in_ready, exp_rdy);
            end
            checks++;
            if (out_valid !== (q.size() > 0)) begin
                errors++;
                $display("FAIL rnd_out_valid @%0d: got %b want %b", cyc, out_valid, q.size() > 0);
            end
            if (q.size() > 0) begin
                checks++;
                if (out_inst !== q[0].inst || out_is_prefix !== q[0].pre || out_is_last !== q[0].last) begin
                    errors++;
                    $display("FAIL rnd_uop @%0d: got inst=%h pre=%b last=%b want inst=%h pre=%b last=%b",
                             cyc, out_inst, out_is_prefix, out_is_last, q[0].inst, q[0].pre, q[0].last);
                end
            end
            checks++;
            if (split_cnt !== m_cnt) begin
                errors++;
                $display("FAIL rnd_split_cnt @%0d: got %0d want %0d", cyc, split_cnt, m_cnt);
            end
            acc = in_valid && exp_rdy;
            if (flush) begin
                q.delete();
            end else begin
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (acc) begin
                    if (ref_split(r)) begin
                        u.inst = ref_prefix(r); u.pre = 1; u.last = 0; q.push_back(u);
                        u.inst = r;             u.pre = 0; u.last = 1; q.push_back(u);
                        m_cnt = m_cnt + 8'd1;
                    end else begin
                        u.inst = r; u.pre = 0; u.last = 1; q.push_back(u);
                    end
                end
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; out_ready = 1'b1;
        test_reset();
        test_pass();
        test_split_sb();
        test_stall_sh();
        test_sw_pass();
        test_flush();
        test_reset_mid_split();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
